// File: rtl/cur_buf_pkg.sv
// Shared definitions for the current-block buffer controller.
//   BUS_W           : pixel bus width in bits
//   BLK_BYTES       : bytes in one 8x8 current block
//   WORDS_PER_BLOCK : bus transfers per block
//   cur_ctrl_state_t: controller FSM states
package cur_buf_pkg;

  localparam int unsigned BUS_W           = 32;
  localparam int unsigned BLK_BYTES       = 64;
  localparam int unsigned WORDS_PER_BLOCK = BLK_BYTES * 8 / BUS_W;

  typedef enum logic [2:0] {
    StIdle,
    StPreload,
    StSwap,
    StRun,
    StWaitLoad,
    StDrain
  } cur_ctrl_state_t;

endpackage

// File: rtl/cur_buffer_ctrl.sv
// Sequencer for the ping-pong current-block buffer of the motion-estimation engine.
// Loads each block into the back half, swaps halves, waits out the swap window and
// then hands the block to the PE array while the next block is prefetched.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : pulse, begin a frame (only honoured when idle)
//   mem_valid / mem_ready : pixel source handshake
//   read_en               : buffer write strobe (one word per cycle)
//   next_block            : pulse, buffer swaps halves
//   fetch_idx             : block index the source must supply
//   blk_valid, blk_idx    : buffer output holds a stable block, and which one
//   pe_start / pe_done    : PE array handshake pulses
//   frame_done            : pulse, last block consumed
//   busy                  : controller not idle
module cur_buffer_ctrl #(
  parameter int unsigned WORDS_PER_BLOCK = 16,
  parameter int unsigned SWAP_LAT        = 7,
  parameter int unsigned NUM_BLOCKS      = 16,
  parameter int unsigned IDX_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_valid,
  output logic             mem_ready,
  output logic             read_en,
  output logic             next_block,
  output logic [IDX_W-1:0] fetch_idx,
  output logic             blk_valid,
  output logic [IDX_W-1:0] blk_idx,
  output logic             pe_start,
  input  logic             pe_done,
  output logic             frame_done,
  output logic             busy
);

  import cur_buf_pkg::*;

  localparam int unsigned WcntW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int unsigned ScntW = (SWAP_LAT > 1) ? $clog2(SWAP_LAT) : 1;

  localparam logic [WcntW-1:0] WordLast = WcntW'(WORDS_PER_BLOCK - 1);
  localparam logic [ScntW-1:0] SwapLast = ScntW'(SWAP_LAT - 1);
  localparam logic [IDX_W-1:0] BlkLast  = IDX_W'(NUM_BLOCKS - 1);

  cur_ctrl_state_t  state;
  logic [WcntW-1:0] word_cnt;
  logic [ScntW-1:0] swap_cnt;
  logic [IDX_W-1:0] blk_cnt;
  logic [IDX_W-1:0] blk_inc;
  logic             back_full;
  logic             final_xfer;

  // The back half may only be written while it is not on the output (i.e. not in SWAP).
  always_comb begin
    mem_ready = 1'b0;
    if ((state == StPreload) || (state == StRun) || (state == StWaitLoad)) begin
      mem_ready = ~back_full;
    end
  end

  assign read_en    = mem_valid & mem_ready;
  assign final_xfer = read_en & (word_cnt == WordLast);
  assign busy       = (state != StIdle);
  assign blk_inc    = (blk_cnt == BlkLast) ? blk_cnt : blk_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      word_cnt   <= '0;
      swap_cnt   <= '0;
      blk_cnt    <= '0;
      back_full  <= 1'b0;
      fetch_idx  <= '0;
      blk_idx    <= '0;
      blk_valid  <= 1'b0;
      next_block <= 1'b0;
      pe_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      next_block <= 1'b0;
      pe_start   <= 1'b0;
      frame_done <= 1'b0;

      // Exactly WORDS_PER_BLOCK writes per block keep the buffer address aligned.
      if (read_en) begin
        if (word_cnt == WordLast) begin
          word_cnt  <= '0;
          back_full <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      case (state)
        StIdle: begin
          if (start) begin
            state     <= StPreload;
            blk_cnt   <= '0;
            word_cnt  <= '0;
            fetch_idx <= '0;
            back_full <= 1'b0;
          end
        end
        StPreload: begin
          if (final_xfer) begin
            state      <= StSwap;
            next_block <= 1'b1;
            swap_cnt   <= '0;
          end
        end
        StSwap: begin
          // next_block is high only in the first SWAP cycle
          if (next_block) begin
            back_full <= 1'b0;
            blk_idx   <= blk_cnt;
          end
          if (swap_cnt == SwapLast) begin
            pe_start  <= 1'b1;
            blk_valid <= 1'b1;
            if (blk_cnt == BlkLast) begin
              state     <= StDrain;
              fetch_idx <= '0;
            end else begin
              state     <= StRun;
              fetch_idx <= blk_cnt + 1'b1;
            end
          end else begin
            swap_cnt <= swap_cnt + 1'b1;
          end
        end
        StRun: begin
          if (pe_done) begin
            blk_valid <= 1'b0;
            if (back_full || final_xfer) begin
              state      <= StSwap;
              next_block <= 1'b1;
              swap_cnt   <= '0;
              blk_cnt    <= blk_inc;
            end else begin
              state <= StWaitLoad;
            end
          end
        end
        StWaitLoad: begin
          if (final_xfer) begin
            state      <= StSwap;
            next_block <= 1'b1;
            swap_cnt   <= '0;
            blk_cnt    <= blk_inc;
          end
        end
        StDrain: begin
          if (pe_done) begin
            state      <= StIdle;
            frame_done <= 1'b1;
            blk_valid  <= 1'b0;
            blk_idx    <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
